// File: rtl/wfg_receive_spi_if.sv
// Word output stream of the SPI receiver: valid/ready handshake with a
// 32-bit right-aligned data word.
interface wfg_receive_spi_if;
    logic [31:0] m_axis_tdata_o;
    logic        m_axis_tvalid_o;
    logic        m_axis_tready_i;

    modport master (
        output m_axis_tdata_o,
        output m_axis_tvalid_o,
        input  m_axis_tready_i
    );

    modport slave (
        input  m_axis_tdata_o,
        input  m_axis_tvalid_o,
        output m_axis_tready_i
    );
endinterface

// File: rtl/wfg_receive_spi.sv
// SPI slave receiver: oversamples SCLK/CS/SDI on clk, assembles 8/16/24/32-bit
// words (MSB first, right-aligned) and queues them in a small output FIFO.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for CS to fall while enabled
// SHIFT   | inside a CS frame, shifting bits and emitting complete words
module wfg_receive_spi #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_en_i,
    input  logic                     cfg_cpol_i,
    input  logic                     cfg_cpha_i,
    input  logic [1:0]               cfg_size_i,
    input  logic                     spi_sclk_i,
    input  logic                     spi_cs_i,
    input  logic                     spi_sdi_i,
    wfg_receive_spi_if.master        m_axis,
    output logic                     overflow_o,
    output logic                     frame_err_o,
    input  logic                     clr_err_i
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    state_t      state_q, state_d;

    logic        sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic        cs_meta_q, cs_sync_q, cs_prev_q;
    logic        sdi_meta_q, sdi_sync_q;

    logic        sclk_rise, sclk_fall, sample_edge;
    logic        cs_fall, cs_rise;

    logic [5:0]  word_bits;
    logic [5:0]  bit_cnt_q;
    logic [31:0] shift_q;
    logic [31:0] shift_next;

    logic        shift_en, word_done, word_clr, ferr_set, ovf_set;

    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          fifo_full, fifo_empty, fifo_wr, fifo_rd;

    // Two-flop synchronizers plus one history flop for edge detection. The CS
    // chain resets low so a CS held low across reset never looks like a fresh
    // falling edge; reception then waits for the next real frame start.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_prev_q <= 1'b0;
            cs_meta_q   <= 1'b0;
            cs_sync_q   <= 1'b0;
            cs_prev_q   <= 1'b0;
            sdi_meta_q  <= 1'b0;
            sdi_sync_q  <= 1'b0;
        end else begin
            sclk_meta_q <= spi_sclk_i;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            cs_meta_q   <= spi_cs_i;
            cs_sync_q   <= cs_meta_q;
            cs_prev_q   <= cs_sync_q;
            sdi_meta_q  <= spi_sdi_i;
            sdi_sync_q  <= sdi_meta_q;
        end
    end

    assign sclk_rise   = sclk_sync_q & ~sclk_prev_q;
    assign sclk_fall   = ~sclk_sync_q & sclk_prev_q;
    assign sample_edge = (cfg_cpol_i == cfg_cpha_i) ? sclk_rise : sclk_fall;
    assign cs_fall     = ~cs_sync_q & cs_prev_q;
    assign cs_rise     = cs_sync_q & ~cs_prev_q;

    // Word length in bits from the size code.
    always_comb begin
        word_bits = 6'd8;
        case (cfg_size_i)
            2'd0:    word_bits = 6'd8;
            2'd1:    word_bits = 6'd16;
            2'd2:    word_bits = 6'd24;
            default: word_bits = 6'd32;
        endcase
    end

    // The shift register only ever holds the bits of the current word, so the
    // shifted value is already right-aligned and zero-extended.
    assign shift_next = {shift_q[30:0], sdi_sync_q};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        state_d   = state_q;
        shift_en  = 1'b0;
        word_done = 1'b0;
        word_clr  = 1'b0;
        ferr_set  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_en_i && cs_fall) begin
                    state_d  = ST_SHIFT;
                    word_clr = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (!cfg_en_i) begin
                    state_d  = ST_IDLE;
                    word_clr = 1'b1;
                end else if (cs_rise) begin
                    state_d  = ST_IDLE;
                    word_clr = 1'b1;
                    ferr_set = (bit_cnt_q != 6'd0);
                end else if (sample_edge) begin
                    shift_en  = 1'b1;
                    word_done = ((bit_cnt_q + 6'd1) == word_bits);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bit counter and shift register; both restart after every complete word.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q <= 6'd0;
            shift_q   <= 32'd0;
        end else if (word_clr || word_done) begin
            bit_cnt_q <= 6'd0;
            shift_q   <= 32'd0;
        end else if (shift_en) begin
            bit_cnt_q <= bit_cnt_q + 6'd1;
            shift_q   <= shift_next;
        end
    end

    assign fifo_full  = (count_q == DEPTH_CNT);
    assign fifo_empty = (count_q == '0);
    assign fifo_rd    = ~fifo_empty & m_axis.m_axis_tready_i;
    assign fifo_wr    = word_done & (~fifo_full | fifo_rd);
    assign ovf_set    = word_done & fifo_full & ~fifo_rd;

    // FIFO storage; contents are don't-care until the count says otherwise.
    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem_q[wr_ptr_q] <= shift_next;
        end
    end

    // FIFO pointers and occupancy; power-of-two depth lets the pointers wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (fifo_wr) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (fifo_rd) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({fifo_wr, fifo_rd})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign m_axis.m_axis_tvalid_o = ~fifo_empty;
    assign m_axis.m_axis_tdata_o  = fifo_empty ? 32'd0 : mem_q[rd_ptr_q];

    // Sticky error flags; a new event wins over a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_o  <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            overflow_o  <= ovf_set  | (overflow_o  & ~clr_err_i);
            frame_err_o <= ferr_set | (frame_err_o & ~clr_err_i);
        end
    end

endmodule

// File: doc/wfg_receive_spi.md
WFG_RECEIVE_SPI -- requirements
Module: wfg_receive_spi

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, output word buffer depth in words, power of two, minimum 2.
REQ-002 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port cfg_en_i  input  1  receiver enable.
REQ-005 SHALL have port cfg_cpol_i  input  1  SCLK idle level.
REQ-006 SHALL have port cfg_cpha_i  input  1  clock phase.
REQ-007 SHALL have port cfg_size_i  input  2  word size: 0=8, 1=16, 2=24, 3=32 bits.
REQ-008 SHALL have port spi_sclk_i  input  1  serial clock, asynchronous to clk.
REQ-009 SHALL have port spi_cs_i  input  1  chip select, active low, asynchronous.
REQ-010 SHALL have port spi_sdi_i  input  1  serial data, MSB first, asynchronous.
REQ-011 SHALL have port m_axis_tdata_o  output  32  received word.
REQ-012 SHALL have port m_axis_tvalid_o  output  1  word available.
REQ-013 SHALL have port m_axis_tready_i  input  1  downstream accepts word.
REQ-014 SHALL have port overflow_o  output  1  sticky: word dropped because the FIFO was full.
REQ-015 SHALL have port frame_err_o  output  1  sticky: CS deasserted mid-word.
REQ-016 SHALL have port clr_err_i  input  1  clears both sticky flags.

Function
REQ-017 SHALL pass spi_sclk_i, spi_cs_i and spi_sdi_i each through a 2-flop synchronizer before use; correct operation is guaranteed for SCLK frequency <= clk/4.
REQ-018 SHALL detect SCLK edges on the synchronized signal; the sampling edge is rising when cfg_cpol_i == cfg_cpha_i, otherwise falling.
REQ-019 SHALL implement states IDLE and SHIFT: IDLE->SHIFT when cfg_en_i=1 and synchronized CS falls; SHIFT->IDLE on synchronized CS rising or cfg_en_i=0.
REQ-020 In SHIFT, SHALL shift synchronized SDI into the shift register on each sampling edge and increment a bit counter.
REQ-021 When the bit counter reaches the selected size, SHALL write the word to the FIFO on the same clk edge that registers the last bit, then clear the counter and remain in SHIFT, so that multiple words per CS frame are supported.
REQ-022 Words SHALL be right-aligned and zero-extended: for size N, the first received bit lands in tdata[N-1] and tdata[31:N]=0.
REQ-023 m_axis_tvalid_o SHALL rise the clk cycle after a write into an empty FIFO; total latency from last-bit detection to tvalid is 1 cycle.
REQ-024 A word SHALL transfer when tvalid and tready are both 1; tdata and tvalid SHALL be held stable while tvalid=1 and tready=0.
REQ-025 A write attempted while the FIFO is full SHALL be dropped and SHALL set overflow_o; a read and a write in the same cycle on a full FIFO SHALL both succeed.
REQ-026 CS rising in SHIFT with bit counter != 0 SHALL discard the partial word and set frame_err_o.
REQ-027 cfg_en_i falling mid-word SHALL discard the partial word without setting any flag; FIFO contents are kept.
REQ-028 clr_err_i SHALL clear both flags; a new error event in the same cycle SHALL take priority and set its flag.
REQ-029 Changes to cfg_cpol_i, cfg_cpha_i and cfg_size_i are valid only in IDLE; behaviour when they change in SHIFT is undefined.

Reset
REQ-030 On rst=1, state=IDLE, bit counter=0, shift register=0, FIFO empty, m_axis_tdata_o=0, m_axis_tvalid_o=0, overflow_o=0, frame_err_o=0.
REQ-031 rst asserted mid-word SHALL discard the partial word; after release, reception resumes only at the next CS falling edge.

Verification
REQ-032 size=3, cpol=0, cpha=0, one frame carrying 0x00006206 -> one word tdata=0x00006206, tvalid high 1 cycle after the last bit.
REQ-033 size=1, one CS frame carrying 0xB509 then 0xEC7F -> two words in order: 0x0000B509, 0x0000EC7F.
REQ-034 tready=0, five 32-bit words sent -> overflow_o=1; after tready=1, exactly the first four words are read in order.
REQ-035 CS raised after 10 of 32 bits -> frame_err_o=1 and no word written; the next full frame 0x0003FFF6 is received correctly; clr_err_i then clears the flag.
REQ-036 cpol=1, cpha=1, size=2, frame carrying 0x033C81 -> tdata=0x00033C81.
REQ-037 rst pulsed after 16 bits, followed by a new frame 0x0000FFFD -> all outputs are 0 during reset, then exactly one word 0x0000FFFD is received.
